// File: rtl/uart_arb_pkg.sv
// Shared encodings and constants for the UART TX message arbiter.
package uart_arb_pkg;
  typedef enum logic [2:0] {IDLE, SEND, ST_CR, ST_LF, DONE} arb_state_t;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam int         MAX_LEN_DEF = 16;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter  int N  = 3,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] win_idx
);
  int jj;

  always_comb begin
    win     = '0;
    win_idx = '0;
    jj      = 0;
    // descending scan: the smallest rotated offset is written last and wins
    for (int k = N - 1; k >= 0; k--) begin
      jj = (int'(ptr) + k) % N;
      if (req[jj]) begin
        win     = N'(1) << jj;
        win_idx = PW'(jj);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Whole-message round-robin arbiter in front of one UART TX FIFO push port.
// Optional UART_TX_ARB_CRLF_EN appends CR LF after every message.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  parameter  int MAX_LEN = MAX_LEN_DEF,
  localparam int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*8-1:0]     req_data,
  output logic [LEN_W-1:0]         byte_idx,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     tx_push,
  output logic [7:0]               tx_data,
  input  logic                     tx_full
);
  arb_state_t         state;
  logic [PTR_W-1:0]   rr_ptr, win, pick_idx, ptr_nxt;
  logic [NUM_REQ-1:0] pick_oh;
  logic [LEN_W-1:0]   len, len_raw, len_in;
  logic               cur_req;
  logic [7:0]         cur_data;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req     (req),
    .ptr     (rr_ptr),
    .win     (pick_oh),
    .win_idx (pick_idx)
  );

  assign len_raw  = req_len[int'(pick_idx)*LEN_W +: LEN_W];
  assign len_in   = (len_raw > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_raw;
  assign cur_req  = req[win];
  assign cur_data = req_data[int'(win)*8 +: 8];
  assign ptr_nxt  = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  assign busy     = (state != IDLE);

  // a dropped request kills the push in the same cycle it falls
  always_comb begin
    tx_push = 1'b0;
    tx_data = 8'h00;
    if (cur_req && !tx_full) begin
      case (state)
        SEND:    if (len != '0) begin tx_push = 1'b1; tx_data = cur_data; end
        ST_CR:   begin tx_push = 1'b1; tx_data = CH_CR; end
        ST_LF:   begin tx_push = 1'b1; tx_data = CH_LF; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      win      <= '0;
      len      <= '0;
      grant    <= '0;
      done     <= '0;
      byte_idx <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: if (|req) begin
          grant    <= pick_oh;
          win      <= pick_idx;
          len      <= len_in;
          byte_idx <= '0;
          state    <= SEND;
        end
        SEND, ST_CR, ST_LF: begin
          if (!cur_req) begin
            state    <= IDLE;
            grant    <= '0;
            byte_idx <= '0;
            rr_ptr   <= ptr_nxt;
          end else if (state == SEND) begin
            if (len == '0 || (tx_push && byte_idx == len - 1'b1)) begin
`ifdef UART_TX_ARB_CRLF_EN
              state <= ST_CR;
`else
              state <= DONE;
              done  <= grant;
`endif
            end else if (tx_push) begin
              byte_idx <= byte_idx + 1'b1;
            end
          end else if (tx_push) begin
            if (state == ST_CR) state <= ST_LF;
            else begin
              state <= DONE;
              done  <= grant;
            end
          end
        end
        DONE: begin
          grant    <= '0;
          byte_idx <= '0;
          rr_ptr   <= ptr_nxt;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART TX FIFO push port (push, 8-bit data, full flag) between NUM_REQ message sources, e.g. stopwatch, DHT and SR04 formatters.
- Arbitrates round-robin at whole-message granularity, so bytes from different sources never interleave.
- The winning source's bytes are streamed into the FIFO and honour backpressure from tx_full.
- Sits between the sensor/stopwatch formatters and the UART top-level push interface.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- MAX_LEN, 16: maximum message length in bytes.
- LEN_W, $clog2(MAX_LEN+1): width of each length field (derived; do not override).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-source request; held high until that source's done pulse.
- req_len  in  NUM_REQ*LEN_W  per-source message length, packed with source i at [i*LEN_W +: LEN_W].
- req_data  in  NUM_REQ*8  per-source byte at index byte_idx, combinational from byte_idx, packed with source i at [i*8 +: 8].
- byte_idx  out  LEN_W  index of the byte currently requested from the granted source.
- grant  out  NUM_REQ  one-hot grant; all zeros when idle.
- done  out  NUM_REQ  one-cycle one-hot pulse when a message is fully pushed.
- busy  out  1  high in any state other than IDLE.
- tx_push  out  1  push strobe to the TX FIFO.
- tx_data  out  8  byte to the TX FIFO.
- tx_full  in  1  TX FIFO full flag.

Behaviour:
- Reset values:
  - state = IDLE; rr pointer = 0.
  - grant = 0, done = 0, busy = 0, byte_idx = 0.
  - tx_push = 0, tx_data = 0.
- States: IDLE, SEND, DONE.
- IDLE:
  - If req != 0, pick the first set bit searching upward from the rr pointer, wrapping modulo NUM_REQ.
  - Register grant, latch len = req_len[winner], set byte_idx = 0, go to SEND.
  - If the latched len is 0, go directly to DONE.
- SEND:
  - tx_push = ~tx_full (combinational).
  - tx_data = req_data[winner] when pushing, else 0.
  - On each push, byte_idx increments.
  - The push with byte_idx == len-1 moves to DONE.
  - While tx_full = 1: no push; byte_idx and grant hold.
- DONE:
  - done[winner] = 1 for exactly one cycle.
  - rr pointer = (winner+1) mod NUM_REQ.
  - grant clears, go to IDLE.
- Latency:
  - First push occurs 1 cycle after req is sampled in IDLE.
  - A message of L bytes with no stall takes L+2 cycles from grant to back in IDLE.
- Abort: if req[winner] drops in SEND, stop pushing that cycle and go to IDLE. No done pulse is issued; the rr pointer still advances past the winner.
- Changes to req_len after grant are ignored, because len is latched.
- Simultaneous requests are resolved by the rr pointer only; requests from losers stay pending.
- Lengths greater than MAX_LEN are clamped to MAX_LEN.
- Reset mid-message returns immediately to the reset values. No partial done pulse is issued; bytes already pushed remain in the FIFO.

Optional Feature:
- Macro: UART_TX_ARB_CRLF_EN.
- When defined:
  - After the last payload byte, SEND pushes 0x0D then 0x0A before DONE, each stallable by tx_full.
  - A len = 0 message sends only CR LF.
  - byte_idx holds at len-1 during the CR and LF pushes.
- When undefined: payload only, exactly as described above.

Decomposition:
- Package uart_arb_pkg holds:
  - the state encoding constants IDLE, SEND, DONE (plus the CR and LF sub-phase codes);
  - CH_CR = 8'h0D and CH_LF = 8'h0A;
  - the default MAX_LEN.
- One natural sub-module, rr_pick: purely combinational.
  - Inputs: req and the rr pointer.
  - Outputs: a one-hot winner and its binary index.
  - Instantiated once.

Test Plan:
- Single request: req[0] = 1, len = 3, bytes 'A','B','C', tx_full = 0 → grant = 001 the next cycle; tx_push high for 3 consecutive cycles with tx_data 0x41, 0x42, 0x43; done = 001 for one cycle; busy low after.
- Contention: req = 101 held together, pointer = 0, len = 2 each → source 0 is served fully, then source 2; no interleaving of bytes; the final rr pointer = 0.
- Backpressure: len = 4, tx_full = 1 for 4 cycles after the second push → no push during the stall, byte_idx holds at 2, the remaining bytes 3 and 4 follow once tx_full falls; exactly 4 pushes in total.
- Zero length: req[1] = 1, len = 0 → no push; done = 010 two cycles after req (with CRLF_EN: exactly 0x0D, 0x0A pushed).
- Abort: len = 5, req[0] drops after 2 pushes → exactly 2 pushes, no done, busy low the next cycle; a pending req[1] is granted next.
- Reset mid-SEND: assert rst after 1 push of a 4-byte message → tx_push, grant, busy, byte_idx all 0 immediately; a clean message is sent after release.
